// File: rtl/fifo_rd_burst_arb.sv
// fifo_rd_burst_arb: round-robin arbiter that shares the async FIFO read port
// among NUM_REQ read-domain consumers, granting each a committed burst.
module fifo_rd_burst_arb #(
    parameter int NUM_REQ = 4,
    parameter int LEN_W = 4,
    parameter int DATA_W = 8,
    localparam int ID_W = $clog2(NUM_REQ)
) (
    input  logic                     rd_clk,
    input  logic                     rd_rstn,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*LEN_W-1:0] req_len,
    output logic [NUM_REQ-1:0]       grant,
    output logic [NUM_REQ-1:0]       done,
    output logic                     busy,
    input  logic                     fifo_empty,
    output logic                     fifo_rd_en,
    input  logic [DATA_W-1:0]        fifo_rdata,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_valid,
    output logic [ID_W-1:0]          out_id
);
    typedef enum logic [1:0] {IDLE, BURST, DONE} state_t;
    state_t state, state_nxt;
    logic [LEN_W-1:0] remaining;
    logic [ID_W-1:0] rr_ptr, win, idx;

    always_ff @(posedge rd_clk or negedge rd_rstn)
        if (!rd_rstn) state <= IDLE;
        else state <= state_nxt;

    // burst ends once the count reaches zero, including a read taken this cycle
    always_comb
        state_nxt = (state == IDLE) ? (|req ? BURST : IDLE) :
                    (state == BURST) ? ((remaining == LEN_W'(fifo_rd_en)) ? DONE : BURST) : IDLE;

    always_comb begin
        fifo_rd_en = (state == BURST) && (remaining != '0) && !fifo_empty;
        done = (state == DONE) ? grant : '0;
        busy = state != IDLE;
        out_data = fifo_rdata;
    end

    // scan from the farthest slot back so the one nearest rr_ptr wins
    always_comb begin
        win = '0;
        idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = ID_W'((int'(rr_ptr) + i) % NUM_REQ);
            if (req[idx]) win = idx;
        end
    end

    always_ff @(posedge rd_clk or negedge rd_rstn)
        if (!rd_rstn) begin
            grant <= '0;
            remaining <= '0;
            out_id <= '0;
            rr_ptr <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= fifo_rd_en;
            if (state == IDLE && |req) begin
                grant <= NUM_REQ'(1) << win;
                remaining <= req_len[win*LEN_W +: LEN_W];
                out_id <= win;
                rr_ptr <= (win == ID_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
            end else if (state == DONE) grant <= '0;
            else if (fifo_rd_en) remaining <= remaining - 1'b1;
        end
endmodule

// File: tb/tb_fifo_rd_burst_arb.sv
// tb_fifo_rd_burst_arb: table-driven, directed and random checks of the read
// burst arbiter against a transaction-level reference model.
module tb_fifo_rd_burst_arb;
    localparam int N = 4, LW = 4, DW = 8, IW = 2;

    logic rd_clk = 1'b0, rd_rstn = 1'b0;
    logic [N-1:0] req = '0;
    logic [N*LW-1:0] req_len = '0;
    logic fifo_empty = 1'b1;
    logic [DW-1:0] fifo_rdata = '0;
    logic [N-1:0] grant, done;
    logic busy, fifo_rd_en, out_valid;
    logic [DW-1:0] out_data;
    logic [IW-1:0] out_id;

    int passed = 0, total = 0;
    int m_owner = -1, m_left = 0, m_rr = 0, m_id = 0;
    bit m_fin = 0, m_ov = 0;

    fifo_rd_burst_arb #(.NUM_REQ(N), .LEN_W(LW), .DATA_W(DW)) dut (
        .rd_clk(rd_clk), .rd_rstn(rd_rstn), .req(req), .req_len(req_len),
        .grant(grant), .done(done), .busy(busy), .fifo_empty(fifo_empty),
        .fifo_rd_en(fifo_rd_en), .fifo_rdata(fifo_rdata), .out_data(out_data),
        .out_valid(out_valid), .out_id(out_id)
    );

    always #5 rd_clk = ~rd_clk;

    typedef struct {
        logic [N-1:0] r;
        logic [LW-1:0] len;
        int exp_owner;
        int exp_reads;
    } vec_t;
    vec_t tbl[10];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    task automatic chk_zero(input string nm);
        check(nm, 32'({grant, done, busy, fifo_rd_en, out_valid, out_id}), 32'd0);
    endtask

    task automatic model_reset();
        m_owner = -1; m_left = 0; m_rr = 0; m_id = 0; m_fin = 0; m_ov = 0;
    endtask

    // One read-clock cycle: drive inputs, compare every output with the model,
    // then advance the model to what the next edge should produce.
    task automatic step(input logic [N-1:0] r, input logic [N*LW-1:0] l, input logic e);
        logic [N-1:0] g;
        bit rd;
        int w;
        @(negedge rd_clk);
        req = r; req_len = l; fifo_empty = e; fifo_rdata = DW'($urandom);
        #1;
        g = (m_owner >= 0) ? N'(1 << m_owner) : '0;
        rd = (m_owner >= 0) && !m_fin && (m_left > 0) && !e;
        check("grant", 32'(grant), 32'(g));
        check("done", 32'(done), 32'(m_fin ? g : '0));
        check("busy_rden_ov", 32'({busy, fifo_rd_en, out_valid}), 32'({m_owner >= 0, rd, m_ov}));
        check("out_id", 32'(out_id), 32'(m_id));
        check("out_data", 32'(out_data), 32'(fifo_rdata));
        m_ov = rd;
        if (m_owner < 0) begin
            if (|r) begin
                w = 0;
                for (int k = 0; k < N; k++)
                    if (r[(m_rr + k) % N]) begin
                        w = (m_rr + k) % N;
                        break;
                    end
                m_owner = w; m_left = int'(l[w*LW +: LW]); m_id = w;
                m_rr = (w + 1) % N; m_fin = 0;
            end
        end else if (m_fin) m_owner = -1;
        else begin
            if (rd) m_left--;
            if (m_left == 0) m_fin = 1;
        end
    endtask

    initial begin
        int owner, reads, gap;
        bit seen;
        logic [N-1:0] rr;
        logic [N*LW-1:0] ll;
        tbl[0] = '{4'b1111, 4'd1, 0, 1};
        tbl[1] = '{4'b1111, 4'd1, 1, 1};
        tbl[2] = '{4'b1111, 4'd1, 2, 1};
        tbl[3] = '{4'b1111, 4'd1, 3, 1};
        tbl[4] = '{4'b1111, 4'd1, 0, 1};
        tbl[5] = '{4'b0010, 4'd3, 1, 3};
        tbl[6] = '{4'b0100, 4'd0, 2, 0};
        tbl[7] = '{4'b0011, 4'd2, 0, 2};
        tbl[8] = '{4'b1001, 4'd15, 3, 15};
        tbl[9] = '{4'b1001, 4'd2, 0, 2};

        #12;
        chk_zero("reset_state");
        @(negedge rd_clk) rd_rstn = 1'b1;

        foreach (tbl[i]) begin
            owner = -1; reads = 0; seen = 0;
            for (int c = 0; c < 40 && !seen; c++) begin
                step(tbl[i].r, {N{tbl[i].len}}, 1'b0);
                if (fifo_rd_en) reads++;
                if (owner < 0)
                    for (int b = 0; b < N; b++) if (grant[b]) owner = b;
                if (|done) seen = 1;
            end
            check("tbl_done_seen", 32'(seen), 32'd1);
            check("tbl_owner", 32'(owner), 32'(tbl[i].exp_owner));
            check("tbl_reads", 32'(reads), 32'(tbl[i].exp_reads));
        end

        // fifo goes empty for two cycles after the second read
        reads = 0; gap = 0; seen = 0;
        for (int c = 0; c < 30 && !seen; c++) begin
            step(4'b0001, {N{4'd4}}, (reads == 2 && gap < 2));
            if (fifo_rd_en) reads++;
            if (reads == 2 && fifo_empty) gap++;
            if (done[0]) seen = 1;
        end
        check("stall_done", 32'(seen), 32'd1);
        check("stall_reads", 32'(reads), 32'd4);
        check("stall_gap", 32'(gap), 32'd2);

        // request withdrawn and length changed once granted
        reads = 0; seen = 0;
        rr = 4'b0001; ll = {N{4'd5}};
        for (int c = 0; c < 30 && !seen; c++) begin
            step(rr, ll, 1'b0);
            if (fifo_rd_en) reads++;
            if (|grant) begin rr = '0; ll = {N{4'd15}}; end
            if (done[0]) seen = 1;
        end
        check("commit_done", 32'(seen), 32'd1);
        check("commit_reads", 32'(reads), 32'd5);

        // asynchronous reset in the middle of a burst
        for (int c = 0; c < 4; c++) step(4'b0100, {N{4'd10}}, 1'b0);
        check("pre_reset_busy", 32'(busy), 32'd1);
        @(negedge rd_clk);
        req = '0; rd_rstn = 1'b0;
        #1;
        chk_zero("reset_midburst");
        model_reset();
        @(posedge rd_clk);
        #1 chk_zero("reset_held");
        @(negedge rd_clk) rd_rstn = 1'b1;
        step(4'b1111, {N{4'd1}}, 1'b0);
        step(4'b1111, {N{4'd1}}, 1'b0);
        check("rr_after_reset", 32'(grant), 32'd1);

        for (int c = 0; c < 3000; c++)
            step(($urandom_range(0, 2) == 0) ? '0 : N'($urandom),
                 (N*LW)'($urandom), ($urandom_range(0, 3) == 0));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
